// File: rtl/rv_imm_pkg.sv
// Shared opcode constants and immediate-format codes for the RV immediate generator.
package rv_imm_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

endpackage

// File: rtl/rv_imm_decode.sv
// Combinational immediate decoder: maps an instruction word to its XLEN immediate and format.
module rv_imm_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  logic [6:0] opcode;
  assign opcode = instr[6:0];

  always_comb begin
    // NOTE: defaults first so every path assigns imm/fmt and no latch is inferred.
    imm = '0;
    fmt = FMT_NONE;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(instr[31:20]));
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          fmt = FMT_I;
          imm = XLEN'($signed(instr[31:20]));
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        // On RV32 the cast is a no-op; on RV64 it sign-extends bit 31.
        fmt = FMT_U;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OPC_SYSTEM: begin
        // Only the immediate CSR forms (funct3[2]=1) carry a zimm in the rs1 field.
        if (instr[14]) begin
          fmt = FMT_Z;
          imm = XLEN'(instr[19:15]);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake, optional skid buffer and flush.
module rv_imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit SKID = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_fmt_o,
  output logic [XLEN-1:0] target_o
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] target;
  } beat_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  beat_t           in_beat;
  beat_t           main_q, main_d, skid_q, skid_d;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic            accept, drain;

  rv_imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (instr_i),
    .imm   (dec_imm),
    .fmt   (dec_fmt)
  );

  assign in_beat = '{instr: instr_i, pc: pc_i, imm: dec_imm, fmt: dec_fmt, target: pc_i + dec_imm};

  // Without a skid, a beat may only enter when the main register is empty or leaving.
  assign in_ready_o = SKID ? !skid_valid_q : (!main_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign drain      = main_valid_q && out_ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // Skid is older than any beat presented now, so it wins the main slot.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: data registers are reset as well so every output reads 0, not X, out of reset.
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so all state updates see the pre-edge values.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign instr_o     = main_q.instr;
  assign pc_o        = main_q.pc;
  assign imm_o       = main_q.imm;
  assign imm_fmt_o   = main_q.fmt;
  assign target_o    = main_q.target;

endmodule
